// File: rtl/counter_8bit_pkg.sv
// Shared counter constants and the next-count helper used by counter_8bit
// and other counters in the slice.
package counter_8bit_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_STEP  = 1;

    // Sum is formed one bit wider than the widest legal count so the carry out
    // of a 32-bit counter is still visible to the terminal-count compare.
    function automatic logic [31:0] next_count(
        input logic [31:0] cur,
        input logic [31:0] step,
        input logic [31:0] max_value,
        input logic        saturate
    );
        logic [32:0] sum;
        logic [32:0] span;
        logic [32:0] wrapped;
        sum     = {1'b0, cur} + {1'b0, step};
        span    = {1'b0, max_value} + 33'd1;
        wrapped = sum - span;
        if (sum > {1'b0, max_value}) begin
            if (saturate) begin
                next_count = max_value;
            end else begin
                next_count = wrapped[31:0];
            end
        end else begin
            next_count = sum[31:0];
        end
    endfunction

endpackage

// File: rtl/counter_8bit.sv
// Free-running up-counter with fixed step and terminal count; wraps by default,
// stops at MAX_VALUE when COUNTER_8BIT_SATURATE_EN is defined.
module counter_8bit
    import counter_8bit_pkg::*;
#(
    parameter int          WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned STEP      = DEFAULT_STEP,
    parameter logic [31:0] MAX_VALUE = 32'((64'd1 << WIDTH) - 64'd1)
) (
    output logic [WIDTH-1:0] value,
    input  logic             clk,
    input  logic             reset
);

`ifdef COUNTER_8BIT_SATURATE_EN
    localparam logic SATURATE = 1'b1;
`else
    localparam logic SATURATE = 1'b0;
`endif

    logic [WIDTH-1:0] value_nxt;

    assign value_nxt = WIDTH'(next_count(32'(value), 32'(STEP), MAX_VALUE, SATURATE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else begin
            value <= value_nxt;
        end
    end

endmodule

// File: tb/tb_counter_8bit.sv
// Self-checking bench for counter_8bit: default instance plus a STEP=3,
// MAX_VALUE=10 instance, compared against an edge-count reference model.
module tb_counter_8bit;

    logic       clk;
    logic       reset;
    logic [7:0] value;
    logic [3:0] value3;

    int checks   = 0;
    int failures = 0;
    longint n    = 0;   // rising edges counted since the last reset release

`ifdef COUNTER_8BIT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    counter_8bit dut (
        .value (value),
        .clk   (clk),
        .reset (reset)
    );

    counter_8bit #(.WIDTH(4), .STEP(3), .MAX_VALUE(32'd10)) dut3 (
        .value (value3),
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count after n edges: n*step reduced modulo (max+1), or clamped at max.
    function automatic logic [31:0] model(input longint edges, input longint step,
                                          input longint maxv);
        longint total;
        total = edges * step;
        if (SAT) model = 32'((total > maxv) ? maxv : total);
        else     model = 32'(total % (maxv + 1));
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t, edges=%0d)", tag, obs, exp, $time, n);
        end
    endtask

    task automatic check_both(input string tag);
        check_eq({tag, "_w8"}, 32'(value), model(n, 1, 255));
        check_eq({tag, "_s3m10"}, 32'(value3), model(n, 3, 10));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (!reset) n++;
        #1;
        check_both(tag);
    endtask

    // Called 1 time unit after an edge: assert reset mid-cycle, hold for
    // 'held' edges, release mid-cycle clear of the next edge.
    task automatic reset_pulse(input int held);
        #2 reset = 1'b1;
        n = 0;
        #1 check_both("rst_async");
        for (int i = 0; i < held; i++) tick("rst_held");
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;

        #17 reset = 1'b1;
        n = 0;
        #1 check_both("rst_t17");
        #10 reset = 1'b0;                       // t=28
        tick("rel_1");                          // edge t=35
        check_eq("first_inc", 32'(value), 32'd1);
        tick("rel_2");                          // edge t=45
        check_eq("second_inc", 32'(value), 32'd2);

        #11 reset = 1'b1;                       // t=57
        n = 0;
        #1 check_both("rst_t57");
        tick("rst_hold_t65");
        check_eq("held_zero", 32'(value), 32'd0);
        #2 reset = 1'b0;                        // t=68
        for (int i = 0; i < 100; i++) tick("run100");
        check_eq("val_t1065", 32'(value), 32'd100);

        // Run through the terminal count of the default instance.
        while (n < 300) tick("long_run");
        check_eq("after300", 32'(value), SAT ? 32'd255 : 32'd44);

        // Mid-count reset at 42: immediate clear, no increment while held.
        reset_pulse(0);
        for (int i = 0; i < 42; i++) tick("to42");
        check_eq("at42", 32'(value), 32'd42);
        reset_pulse(1);
        tick("after42_rel");

        // Randomized run lengths and reset pulses.
        for (int r = 0; r < 25; r++) begin
            int len;
            len = int'($urandom_range(1, 60));
            for (int i = 0; i < len; i++) tick("rand_run");
            reset_pulse(int'($urandom_range(0, 2)));
        end
        for (int i = 0; i < 20; i++) tick("tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: run did not complete, got t=%0t expected below 200000", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_8bit.md
# counter_8bit

Free-running binary up-counter that advances by a fixed step on every rising clock edge. It is a general-purpose timebase and event-index source for the surrounding logic. It has an asynchronous active-high clear and a single registered count output. Module name is `counter_8bit`, and its ports are declared in positional order `value, clk, reset`.

## Interface
- `WIDTH`, default 8: count register width in bits; legal range 2–32.
- `STEP`, default 1: increment added per clock; legal range 1 to 2^WIDTH−1.
- `MAX_VALUE`, default 2^WIDTH−1: terminal count; legal range 1 to 2^WIDTH−1.
- Port order (positional): `value`, `clk`, `reset`.
- `clk`  input  1  sole clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-high clear of the count.
- `value`  output  WIDTH  current count, driven directly from the count register.
- One clock; reset is asynchronous and active-high.

## Operation
- While `reset`=1: `value`=0 immediately (no clock needed) and held at 0 on every edge.
- While `reset`=0, on each rising `clk`: `value` ← `value` + `STEP`.
- Wrap (default build): if `value` + `STEP` > `MAX_VALUE`, next `value` = (`value` + `STEP`) − (`MAX_VALUE` + 1). Default parameters give plain modulo-256 counting: 255 → 0.
- Arithmetic is done at WIDTH+1 bits so that the carry is detected. `value` never exceeds `MAX_VALUE`.
- Reset wins over counting in every cycle.
- Before the first reset assertion, `value` is unspecified (X in simulation). The design does not rely on initializers.

## Timing
- Reset value of `value`: 0.
- Assertion: `value` goes to 0 in the same simulation time step as `reset` rises, asynchronous to `clk`.
- Release: the first increment occurs on the first rising `clk` strictly after `reset` falls. `value` reads 1 (i.e. `STEP`) after that edge.
- `reset` falling coincident with a `clk` rising edge is not a legal input. Upstream synchronizes reset release to be clear of the active edge.
- Latency: one cycle from edge to updated `value`. There are no combinational paths from input to output.
- Reset mid-count: the count is discarded and counting restarts from 0. No state survives a reset.

## Configuration
- Macro `COUNTER_8BIT_SATURATE_EN`.
  - Defined: the counter stops at `MAX_VALUE`. If `value` + `STEP` > `MAX_VALUE`, next `value` = `MAX_VALUE`, and it holds there until reset.
  - Undefined (default): wrap behaviour as in Operation.
- Reset behaviour is identical in both builds.

## Structure
- Shared package `counter_8bit_pkg` holds:
  - the default width constant (8);
  - the default step (1);
  - a function computing the next count given value, step, max and the saturate flag, reused by other counters.
- No sub-module: a single register plus next-state logic is sufficient.

## Test plan
- 5-unit half-period clock; `reset` 1 at t=17 → `value`=0 at t=17, before any edge. Release at t=28 → `value`=1 after the t=35 edge, 2 after t=45.
- Second pulse: `reset` 1 at t=57, 0 at t=68 → `value`=0 from t=57 and held across the t=65 edge. Then 1 at t=75; after the edge at t=1065, `value`=100 (0x64).
- Default build, 255 edges after reset → 255; the next edge → 0, then 1.
- `COUNTER_8BIT_SATURATE_EN` defined, 300 edges after reset → `value`=255 and held; asserting `reset` → 0 immediately.
- `STEP`=3, `MAX_VALUE`=10: sequence after reset is 0, 3, 6, 9, 1, 4, 7, 10, 2. With saturate, the sequence is 0, 3, 6, 9, 10, 10.
- `reset` pulsed mid-cycle between edges while `value`=42 → `value`=0 within the same time step; no increment on the edge during reset.
